// File: rtl/reg_file_32x32.sv
// 32x32 register file for the single-cycle KGP-RISC datapath: async reads, one main and one link write per edge.
// Writes visible the cycle after their edge; no handshake, every write is accepted each cycle.
module reg_file_32x32 #(
   parameter int DATA_W   = 32,
   parameter int NREG     = 32,
   parameter int ZERO_REG = 1,
   parameter int LINK_REG = 31,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        rd_addr1,
   input  logic [4:0]        rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              link_en,
   input  logic [DATA_W-1:0] link_data,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  wr_cnt
);

   localparam logic [5:0] NREG_L = 6'(NREG);
   localparam logic [4:0] LINK_A = 5'(LINK_REG);

   logic [DATA_W-1:0] r_regs [NREG];
   logic [CNT_W-1:0]  r_cnt;
   logic              w_main_ok;
   logic              w_link_ok;
   logic [CNT_W:0]    w_cnt_sum;

   // An address is live if it maps to real storage and is not the hardwired zero register.
   function automatic logic f_addr_live(input logic [4:0] a);
      return ({1'b0, a} < NREG_L) && !((ZERO_REG != 0) && (a == 5'd0));
   endfunction

   // No write-to-read bypass: a bypass would loop through the ALU in a single-cycle core.
   function automatic logic [DATA_W-1:0] f_read(input logic [4:0] a);
      logic [DATA_W-1:0] v;
      v = '0;
      if (f_addr_live(a)) v = r_regs[a];
      return v;
   endfunction

   assign rd_data1 = f_read(rd_addr1);
   assign rd_data2 = f_read(rd_addr2);
   assign dbg_data = f_read(dbg_addr);

   assign w_link_ok = link_en && f_addr_live(LINK_A);
   assign w_main_ok = wr_en && f_addr_live(wr_addr) && !(w_link_ok && (wr_addr == LINK_A));

   assign w_cnt_sum = {1'b0, r_cnt}
                    + {{CNT_W{1'b0}}, w_main_ok}
                    + {{CNT_W{1'b0}}, w_link_ok};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else begin
         if (w_main_ok) r_regs[wr_addr] <= wr_data;
         if (w_link_ok) r_regs[LINK_A]  <= link_data;
      end
   end

   // Carry out of the sum means the increment passed all-ones: clamp there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else        r_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
   end

   assign wr_cnt = r_cnt;

endmodule

// File: tb/tb_reg_file_32x32.sv
// Randomized self-checking bench for reg_file_32x32 against an array-based reference model.
module tb_reg_file_32x32;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rd_addr1, rd_addr2, wr_addr, dbg_addr;
   logic [31:0] rd_data1, rd_data2, wr_data, link_data, dbg_data;
   logic        wr_en, link_en;
   logic [3:0]  wr_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_reg [32];
   int          m_cnt;

   reg_file_32x32 #(.CNT_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .link_en(link_en), .link_data(link_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .wr_cnt(wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : m_reg[a];
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
      m_cnt = 0;
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic do_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic le, input logic [31:0] ld,
                           input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] da);
      int acc;
      wr_en = we; wr_addr = wa; wr_data = wd;
      link_en = le; link_data = ld;
      rd_addr1 = ra1; rd_addr2 = ra2; dbg_addr = da;
      #1;
      chk("old_rd1", rd_data1, m_read(ra1));
      chk("old_rd2", rd_data2, m_read(ra2));
      chk("old_dbg", dbg_data, m_read(da));
      chk("old_cnt", 32'(wr_cnt), 32'(m_cnt));
      @(posedge clk);
      acc = 0;
      if (le) begin
         m_reg[31] = ld;
         acc++;
      end
      if (we && wa != 5'd0 && !(le && wa == 5'd31)) begin
         m_reg[wa] = wd;
         acc++;
      end
      m_cnt = (m_cnt + acc > 15) ? 15 : m_cnt + acc;
      #1;
      chk("new_rd1", rd_data1, m_read(ra1));
      chk("new_rd2", rd_data2, m_read(ra2));
      chk("new_dbg", dbg_data, m_read(da));
      chk("new_cnt", 32'(wr_cnt), 32'(m_cnt));
      @(negedge clk);
      wr_en = 1'b0;
      link_en = 1'b0;
   endtask

   // Reset asserted between edges, held across a rising edge with writes presented.
   task automatic rst_pulse();
      #2;
      wr_en = 1'b1; wr_addr = 5'($urandom); wr_data = $urandom;
      link_en = 1'b1; link_data = $urandom;
      rst_n = 1'b0;
      #1;
      chk("rst_cnt", 32'(wr_cnt), 32'h0);
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         rd_addr1 = 5'(i);
         rd_addr2 = 5'(31 - i);
         #1;
         chk("rst_dbg", dbg_data, 32'h0);
         chk("rst_rd1", rd_data1, 32'h0);
         chk("rst_rd2", rd_data2, 32'h0);
      end
      chk("rst_cnt_hold", 32'(wr_cnt), 32'h0);
      @(negedge clk);
      wr_en = 1'b0;
      link_en = 1'b0;
      rst_n = 1'b1;
      m_clear();
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      link_en = 1'b0; link_data = '0;
      rd_addr1 = 5'd5; rd_addr2 = 5'd31; dbg_addr = 5'd7;
      m_clear();
      #1;
      chk("reset_cnt", 32'(wr_cnt), 32'h0);
      chk("reset_rd1", rd_data1, 32'h0);
      chk("reset_rd2", rd_data2, 32'h0);
      chk("reset_dbg", dbg_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      do_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 5'd5, 5'd5, 5'd5);
      chk("basic_r5", rd_data1, 32'hDEADBEEF);
      chk("basic_cnt", 32'(wr_cnt), 32'd1);

      do_cycle(1'b1, 5'd0, 32'h12345678, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
      chk("r0_read", rd_data1, 32'h0);
      chk("r0_cnt", 32'(wr_cnt), 32'd1);

      do_cycle(1'b1, 5'd31, 32'hAAAA0000, 1'b1, 32'h00000104, 5'd31, 5'd31, 5'd31);
      chk("coll_r31", rd_data1, 32'h00000104);
      chk("coll_cnt", 32'(wr_cnt), 32'd2);

      do_cycle(1'b1, 5'd7, 32'h11, 1'b1, 32'h200, 5'd7, 5'd31, 5'd7);
      chk("dual_r7", rd_data1, 32'h11);
      chk("dual_r31", rd_data2, 32'h200);
      chk("dual_cnt", 32'(wr_cnt), 32'd4);

      for (int i = 1; i <= 20; i++)
         do_cycle(1'b1, 5'(i), $urandom, 1'b0, 32'h0, 5'(i), 5'd1, 5'(i));
      chk("sat_cnt", 32'(wr_cnt), 32'hF);

      rst_pulse();

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            rst_pulse();
         end else begin
            logic [4:0] wa;
            wa = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
            do_cycle($urandom_range(0, 3) != 0, wa, $urandom,
                     $urandom_range(0, 3) == 0, $urandom,
                     5'($urandom), 5'($urandom), 5'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
